// File: rtl/vn_byte_packer_pkg.sv
// vn_byte_packer_pkg: shared types and default sizing for the debiasing byte packer
package vn_byte_packer_pkg;
  typedef enum logic {FIRST, SECOND} pair_e;
  localparam int OUTPUT_SIZE_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RUN_LIMIT_DEF = 32;
  localparam int CNT_W = $clog2(OUTPUT_SIZE_DEF);
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);
  localparam int OCC_W = $clog2(FIFO_DEPTH_DEF + 1);
endpackage

// File: rtl/vn_byte_packer_word_fifo.sv
// vn_byte_packer_word_fifo: first-word fall-through FIFO; output reads zero while empty
module vn_byte_packer_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == OW'(DEPTH);
    empty = count_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + OW'(do_push) - OW'(do_pop);
    dout = empty ? '0 : mem_q[rd_ptr_q];
    count = count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/vn_byte_packer.sv
// vn_byte_packer: von Neumann debiaser, LSB-first word packer, output FIFO and repetition health test
module vn_byte_packer
  import vn_byte_packer_pkg::*;
#(
  parameter int OUTPUT_SIZE = OUTPUT_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RUN_LIMIT = RUN_LIMIT_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                raw_bit,
  input  logic                                raw_en,
  output logic [OUTPUT_SIZE-1:0]              out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                health_fail,
  output logic                                overflow
);
  localparam int CW = $clog2(OUTPUT_SIZE);
  localparam int RW = $clog2(RUN_LIMIT + 1);
  pair_e state_q, state_d;
  logic first_q, first_d, prev_q, prev_d;
  logic [OUTPUT_SIZE-1:0] shift_q, shift_d, word;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic health_fail_q, health_fail_d, overflow_q, overflow_d;
  logic active, emit, push, fifo_full, fifo_empty;
  always_comb begin
    active = raw_en && !health_fail_q;
    emit = active && state_q == SECOND && first_q != raw_bit;
    push = emit && bit_cnt_q == CW'(OUTPUT_SIZE - 1);
    word = {first_q, shift_q[OUTPUT_SIZE-1:1]};
    state_d = health_fail_q ? FIRST : !raw_en ? state_q : state_q == FIRST ? SECOND : FIRST;
    first_d = (active && state_q == FIRST) ? raw_bit : first_q;
    shift_d = emit ? word : shift_q;
    bit_cnt_d = push ? '0 : emit ? bit_cnt_q + 1'b1 : bit_cnt_q;
    // a zero run count marks "no previous sample since reset"
    run_cnt_d = !raw_en ? run_cnt_q
              : (run_cnt_q == '0 || raw_bit != prev_q) ? RW'(1)
              : run_cnt_q == RW'(RUN_LIMIT) ? run_cnt_q : run_cnt_q + 1'b1;
    prev_d = raw_en ? raw_bit : prev_q;
    health_fail_d = health_fail_q || (raw_en && run_cnt_d == RW'(RUN_LIMIT));
    overflow_d = overflow_q || (push && fifo_full);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FIRST;
      first_q <= 1'b0;
      prev_q <= 1'b0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      run_cnt_q <= '0;
      health_fail_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      prev_q <= prev_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      run_cnt_q <= run_cnt_d;
      health_fail_q <= health_fail_d;
      overflow_q <= overflow_d;
    end
  end
  vn_byte_packer_word_fifo #(.WIDTH(OUTPUT_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(word),
    .pop(out_ready),
    .dout(out_data),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign out_valid = !fifo_empty;
  assign health_fail = health_fail_q;
  assign overflow = overflow_q;
endmodule
